// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// Parametrised UART transmitter. One word is accepted per valid/ready
// handshake and sent as: start bit, DATA_W data bits (LSB first), an
// optional parity bit, then STOP_BITS stop bits.
// The baud divisor and parity sense are latched on the accept edge, so they
// may change between frames without disturbing a frame in flight.
// Optional feature macro: UART_TX_PARITY_EN (defined = parity bit present).
// tx_ready is combinational; every other output is registered.

module uart_tx_frame #(
    parameter int DATA_W    = 8,
    parameter int CPB_W     = 16,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CPB_W-1:0]  clks_per_bit,
    input  logic              parity_odd,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              UART_line,
    output logic              busy,
    output logic              done
);

    // Bit counter must reach DATA_W-1 (the largest count used).
    localparam int BCW = $clog2(DATA_W + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_W - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Parity bit over the whole word; odd selects inverted (odd) parity.
    function automatic logic f_parity(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction
`endif

    // Registered state
    state_t             r_state;
    logic [CPB_W-1:0]   r_div_cnt;
    logic [CPB_W-1:0]   r_div_last;
    logic [BCW-1:0]     r_bit_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_line;
    logic               r_busy;
    logic               r_done;
`ifdef UART_TX_PARITY_EN
    logic               r_par;
`endif

    // Next-state values
    state_t             w_state_nxt;
    logic [CPB_W-1:0]   w_div_nxt;
    logic [CPB_W-1:0]   w_div_last_nxt;
    logic [BCW-1:0]     w_bit_nxt;
    logic [DATA_W-1:0]  w_shift_nxt;
    logic               w_line_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
`ifdef UART_TX_PARITY_EN
    logic               w_par_nxt;
`else
    logic               w_unused_parity_odd;
    assign w_unused_parity_odd = parity_odd;
`endif

    logic               w_wrap;
    logic               w_ready;
    logic               w_accept;
    logic [CPB_W-1:0]   w_cpb_last;

    // A bit ends on the cycle the divisor counter reaches its latched limit.
    assign w_wrap = (r_div_cnt == r_div_last);

    // A divisor of zero behaves as one cycle per bit (limit L-1 = 0).
    assign w_cpb_last = (clks_per_bit == {CPB_W{1'b0}}) ? {CPB_W{1'b0}}
                                                        : (clks_per_bit - CPB_W'(1));

    // Ready in idle, and in the final cycle of the last stop bit for gapless frames.
    always_comb begin
        w_ready = 1'b0;
        if (!rst) begin
            w_ready = 1'b0;
        end else if (r_state == S_IDLE) begin
            w_ready = 1'b1;
        end else if ((r_state == S_STOP) && (r_bit_cnt == LAST_STOP) && w_wrap) begin
            w_ready = 1'b1;
        end else begin
            w_ready = 1'b0;
        end
    end

    assign w_accept = tx_valid && w_ready;
    assign tx_ready = w_ready;

    // Frame sequencer: next state, bit timing, shift register and line value.
    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div_cnt;
        w_div_last_nxt = r_div_last;
        w_bit_nxt      = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_line_nxt     = r_line;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_nxt      = r_par;
`endif
        if (w_accept) begin
            // Accept: latch word and settings, start bit goes out immediately.
            // Accept only happens in idle or at the end of the last stop bit,
            // so coming from STOP means a frame just completed.
            w_state_nxt    = S_START;
            w_div_nxt      = {CPB_W{1'b0}};
            w_div_last_nxt = w_cpb_last;
            w_bit_nxt      = {BCW{1'b0}};
            w_shift_nxt    = tx_data;
            w_line_nxt     = 1'b0;
            w_busy_nxt     = 1'b1;
            w_done_nxt     = (r_state == S_STOP);
`ifdef UART_TX_PARITY_EN
            w_par_nxt      = f_parity(tx_data, parity_odd);
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_div_nxt  = {CPB_W{1'b0}};
                    w_bit_nxt  = {BCW{1'b0}};
                    w_line_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                end
                S_START: begin
                    if (w_wrap) begin
                        w_div_nxt   = {CPB_W{1'b0}};
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = {BCW{1'b0}};
                        w_line_nxt  = r_shift[0];
                        w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
                    end else begin
                        w_div_nxt   = r_div_cnt + CPB_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_wrap) begin
                        w_div_nxt = {CPB_W{1'b0}};
                        if (r_bit_cnt == LAST_DATA) begin
                            w_bit_nxt   = {BCW{1'b0}};
`ifdef UART_TX_PARITY_EN
                            w_state_nxt = S_PARITY;
                            w_line_nxt  = r_par;
`else
                            w_state_nxt = S_STOP;
                            w_line_nxt  = 1'b1;
`endif
                        end else begin
                            w_bit_nxt   = r_bit_cnt + BCW'(1);
                            w_line_nxt  = r_shift[0];
                            w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
                        end
                    end else begin
                        w_div_nxt = r_div_cnt + CPB_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_wrap) begin
                        w_div_nxt   = {CPB_W{1'b0}};
                        w_state_nxt = S_STOP;
                        w_bit_nxt   = {BCW{1'b0}};
                        w_line_nxt  = 1'b1;
                    end else begin
                        w_div_nxt   = r_div_cnt + CPB_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_wrap) begin
                        w_div_nxt = {CPB_W{1'b0}};
                        if (r_bit_cnt == LAST_STOP) begin
                            w_state_nxt = S_IDLE;
                            w_bit_nxt   = {BCW{1'b0}};
                            w_line_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_bit_nxt   = r_bit_cnt + BCW'(1);
                        end
                    end else begin
                        w_div_nxt = r_div_cnt + CPB_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_div_nxt   = {CPB_W{1'b0}};
                    w_bit_nxt   = {BCW{1'b0}};
                    w_line_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_div_cnt  <= {CPB_W{1'b0}};
            r_div_last <= {CPB_W{1'b0}};
            r_bit_cnt  <= {BCW{1'b0}};
            r_shift    <= {DATA_W{1'b0}};
            r_line     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_div_cnt  <= w_div_nxt;
            r_div_last <= w_div_last_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_line     <= w_line_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
            r_par      <= w_par_nxt;
`endif
        end
    end

    assign UART_line = r_line;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises one word per valid/ready handshake into a start bit, DATA_W data bits (LSB first), an optional parity bit and one or two stop bits. It replaces the fixed 8-bit/even-parity/start-pulse transmitter in the UART path. It sits between a host-side producer, such as a FIFO or register block, and the physical TX line that feeds the RX module. The baud divisor is a runtime input, latched per frame, so baud rate can change between frames without corrupting a frame in flight.

## Interface
- DATA_W, 8, data bits per frame; legal range 5..9.
- CPB_W, 16, width of the clks_per_bit divisor input.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- clk  input  1  single clock for all logic.
- rst  input  1  synchronous, active-low reset, sampled on posedge clk.
- clks_per_bit  input  CPB_W  clk cycles per bit; value 0 is treated as 1.
- parity_odd  input  1  0 = even parity, 1 = odd parity; ignored when parity is compiled out.
- tx_data  input  DATA_W  word to send; sampled on the accept edge.
- tx_valid  input  1  producer has a word.
- tx_ready  output  1  transmitter can accept a word this cycle.
- UART_line  output  1  serial output; idles high.
- busy  output  1  high from the accept edge until the final stop bit ends.
- done  output  1  one-cycle pulse in the cycle after the final stop bit ends.

## Operation
- Reset: on any posedge clk with rst=0, the block forces the following, including mid-frame (the frame is aborted with no partial stop bit):
  - state=IDLE, UART_line=1, busy=0, done=0;
  - bit counter and divisor counter cleared;
  - tx_ready=0 while rst=0, and 1 on the first cycle after rst returns high.
- Accept: the handshake completes when tx_valid && tx_ready at a posedge. On that edge the block:
  - latches tx_data into the shift register;
  - latches clks_per_bit and parity_odd;
  - enters START, drives UART_line=0 and sets busy=1.
- States:
  - IDLE: tx_ready=1, UART_line=1.
  - START: one bit time, then DATA.
  - DATA: DATA_W bit times, shifting LSB first.
  - PARITY: one bit time; present only when compiled in.
  - STOP: STOP_BITS bit times at UART_line=1.
  - From STOP the block goes to IDLE, or directly to START on a back-to-back accept.
- Bit timing: the divisor counter runs 0..L-1, where L is the latched clks_per_bit (minimum 1). Each bit lasts exactly L cycles. UART_line changes only on the edge where the counter wraps.
- Parity bit value = (^data) XOR parity_odd, computed over the latched word.
- tx_ready is combinational. It is high in IDLE, and also in the last cycle of the final stop bit (counter = L-1). This gives zero-gap back-to-back frames.
- Back-to-back accept: the next START follows the stop bit with no idle cycle. busy stays 1, and done still pulses for the completed frame.
- Changes to clks_per_bit or parity_odd while busy have no effect until the next accept.
- tx_data changes while tx_valid=0 or tx_ready=0 are ignored.

## Timing
- Accept-to-line latency: UART_line falls on the accept edge itself and is visible in the following cycle.
- Frame length: (1 + DATA_W + P + STOP_BITS) × L cycles, where P = 1 if parity is compiled in, else 0.
- done asserts for exactly one cycle, starting at the edge that ends the last stop bit.
- All outputs are registered except tx_ready.

## Configuration
- UART_TX_PARITY_EN
  - Defined: the PARITY state is present and each frame carries one parity bit between data and stop.
  - Undefined: PARITY state and parity logic are removed; parity_odd is unused; P = 0.

## Test plan
- Parity enabled, DATA_W=8, STOP_BITS=1, clks_per_bit=4, parity_odd=0, tx_data=0xA5, one accept:
  - UART_line sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,0(parity),1(stop).
  - busy high for 44 cycles; done pulses once.
- Same as above with parity_odd=1: parity bit = 1; all other bits unchanged.
- Back-to-back: tx_valid held high with 0x00 then 0xFF, clks_per_bit=2:
  - the second start bit immediately follows the first stop bit;
  - tx_ready is high for exactly one cycle during frame 1;
  - done pulses twice, 22 cycles apart.
- Reset mid-frame: assert rst=0 during data bit 3 for one cycle:
  - next cycle UART_line=1, busy=0, done=0;
  - after release, tx_ready=1 and a new frame of 0x3C transmits correctly.
- Divisor change and edge cases:
  - change clks_per_bit from 4 to 8 mid-frame: the current frame keeps 4-cycle bits; the next frame uses 8;
  - clks_per_bit=0 produces 1-cycle bits.
- Parity compiled out, DATA_W=7, STOP_BITS=2, clks_per_bit=3, tx_data=0x41:
  - UART_line sequence: 0,1,0,0,0,0,0,1,1,1;
  - frame length 30 cycles.
